uart_tx_fifo: RTL and testbench

- Byte queue sitting directly upstream of UART_TX. Host logic writes bytes at any rate; the block paces them into UART_TX.
- Issues one-cycle TX_Send pulses with Input_Byte, then waits for Main_TX_Active to rise and fall before launching the next byte.
- Decouples bursty producers from the 115200-baud serial line (217 clocks/bit at 25 MHz).

---
 rtl/uart_tx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of UART_TX: buffers host writes and launches one byte at a time,
// pacing launches on the transmitter's Main_TX_Active handshake.
module uart_tx_fifo #(
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_N,
    input  logic                  Write_Enable,
    input  logic [7:0]            Write_Byte,
    output logic                  FIFO_Full,
    output logic                  FIFO_Empty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  Send_Error,
    output logic                  Busy,
    output logic                  TX_Send,
    output logic [7:0]            Input_Byte,
    input  logic                  TX_Active,
    output logic [1:0]            Fsm_State
);

    // Handshake: TX_Send is a one-cycle request; the transmitter acknowledges by raising
    // TX_Active within START_TIMEOUT clocks and signals completion by dropping it.
    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] LAUNCH      = 2'd1;
    localparam logic [1:0] WAIT_ACTIVE = 2'd2;
    localparam logic [1:0] WAIT_DONE   = 2'd3;

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0]       TIMEOUT_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT    = (ADDR_WIDTH + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [TW-1:0]         timer;
    logic                  pop;
    logic                  push;
    logic [ADDR_WIDTH:0]   count_next;

    // A pop frees a slot in the same cycle, so a full queue still accepts a write then.
    assign pop  = (Fsm_State == IDLE) && !FIFO_Empty;
    assign push = Write_Enable && (!FIFO_Full || pop);

    always_comb begin
        count_next = Count;
        if (push && !pop) begin
            count_next = Count + 1'b1;
        end else if (pop && !push) begin
            count_next = Count - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= Write_Byte;
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Count      <= '0;
            FIFO_Full  <= 1'b0;
            FIFO_Empty <= 1'b1;
            Overflow   <= 1'b0;
            Send_Error <= 1'b0;
            Busy       <= 1'b0;
            TX_Send    <= 1'b0;
            Input_Byte <= 8'h00;
            timer      <= '0;
            Fsm_State  <= IDLE;
        end else begin
            Count      <= count_next;
            FIFO_Full  <= (count_next == DEPTH_CNT);
            FIFO_Empty <= (count_next == '0);
            Overflow   <= Write_Enable && FIFO_Full && !pop;
            Send_Error <= 1'b0;
            TX_Send    <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (Fsm_State)
                IDLE: begin
                    if (pop) begin
                        Input_Byte <= mem[rd_ptr];
                        TX_Send    <= 1'b1;
                        Busy       <= 1'b1;
                        Fsm_State  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer     <= '0;
                    Fsm_State <= WAIT_ACTIVE;
                end
                WAIT_ACTIVE: begin
                    if (TX_Active) begin
                        Fsm_State <= WAIT_DONE;
                    end else if (timer == TIMEOUT_LAST) begin
                        // The transmitter never answered; the byte is dropped, not re-queued.
                        Send_Error <= 1'b1;
                        Busy       <= 1'b0;
                        Fsm_State  <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!TX_Active) begin
                        Busy      <= 1'b0;
                        Fsm_State <= IDLE;
                    end
                end
                default: begin
                    Busy      <= 1'b0;
                    Fsm_State <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; the bench plays the role of UART_TX by driving TX_Active.
module tb_uart_tx_fifo;

    logic       Clock = 1'b0;
    logic       Reset_N;
    logic       Write_Enable;
    logic [7:0] Write_Byte;
    logic       FIFO_Full;
    logic       FIFO_Empty;
    logic [4:0] Count;
    logic       Overflow;
    logic       Send_Error;
    logic       Busy;
    logic       TX_Send;
    logic [7:0] Input_Byte;
    logic       TX_Active;
    logic [1:0] Fsm_State;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 Clock = ~Clock;

    uart_tx_fifo #(.DEPTH(16), .ADDR_WIDTH(4), .START_TIMEOUT(8)) dut (
        .Clock(Clock), .Reset_N(Reset_N), .Write_Enable(Write_Enable), .Write_Byte(Write_Byte),
        .FIFO_Full(FIFO_Full), .FIFO_Empty(FIFO_Empty), .Count(Count), .Overflow(Overflow),
        .Send_Error(Send_Error), .Busy(Busy), .TX_Send(TX_Send), .Input_Byte(Input_Byte),
        .TX_Active(TX_Active), .Fsm_State(Fsm_State)
    );

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Reset_N      = 1'b0;
        Write_Enable = 1'b0;
        Write_Byte   = 8'h00;
        TX_Active    = 1'b0;
        repeat (3) tick;
        Reset_N = 1'b1;
        tick;
    endtask

    // Expects the FSM in WAIT_DONE with TX_Active just dropped; emulates one full frame.
    task automatic run_frame(input int hold);
        int lat;
        logic [7:0] exp_b;
        lat = 0;
        while (TX_Send !== 1'b1 && lat < 10) begin
            tick;
            lat++;
        end
        checks++; if (lat != 2) begin failures++; $display("FAIL launch_latency: got %0d cycles, want 2", lat); end
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (Input_Byte !== exp_b) begin failures++; $display("FAIL frame_byte: got %h want %h", Input_Byte, exp_b); end
        tick;
        checks++; if (TX_Send !== 1'b0) begin failures++; $display("FAIL tx_send_width: got %b want 0", TX_Send); end
        TX_Active = 1'b1;
        tick;
        repeat (hold) begin
            tick;
            checks++; if (TX_Send !== 1'b0 || Input_Byte !== exp_b) begin failures++; $display("FAIL hold_during_active: send=%b byte=%h want 0/%h", TX_Send, Input_Byte, exp_b); end
        end
        TX_Active = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (Count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", Count); end
        checks++; if (FIFO_Empty !== 1'b1 || FIFO_Full !== 1'b0) begin failures++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", FIFO_Empty, FIFO_Full); end
        checks++; if (TX_Send !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL reset_fsm: send=%b busy=%b want 0/0", TX_Send, Busy); end
        checks++; if (Overflow !== 1'b0 || Send_Error !== 1'b0) begin failures++; $display("FAIL reset_pulses: ovf=%b err=%b want 0/0", Overflow, Send_Error); end
        checks++; if (Input_Byte !== 8'h00 || Fsm_State !== 2'd0) begin failures++; $display("FAIL reset_byte_state: byte=%h state=%0d want 00/0", Input_Byte, Fsm_State); end
    endtask

    task automatic test_single;
        Write_Enable = 1'b1; Write_Byte = 8'hA5;
        tick;
        Write_Enable = 1'b0;
        checks++; if (Count !== 5'd1 || FIFO_Empty !== 1'b0) begin failures++; $display("FAIL single_count1: count=%0d empty=%b want 1/0", Count, FIFO_Empty); end
        checks++; if (TX_Send !== 1'b0) begin failures++; $display("FAIL single_early: send=%b want 0", TX_Send); end
        tick;
        checks++; if (TX_Send !== 1'b1 || Input_Byte !== 8'hA5) begin failures++; $display("FAIL single_launch: send=%b byte=%h want 1/a5", TX_Send, Input_Byte); end
        checks++; if (Count !== 5'd0 || Busy !== 1'b1) begin failures++; $display("FAIL single_pop: count=%0d busy=%b want 0/1", Count, Busy); end
        tick;
        checks++; if (TX_Send !== 1'b0) begin failures++; $display("FAIL single_pulse: send=%b want 0", TX_Send); end
        TX_Active = 1'b1;
        repeat (5) tick;
        TX_Active = 1'b0;
        tick;
        checks++; if (Busy !== 1'b0 || Input_Byte !== 8'hA5) begin failures++; $display("FAIL single_done: busy=%b byte=%h want 0/a5", Busy, Input_Byte); end
        tick;
    endtask

    task automatic test_burst_full;
        int exp_cnt;
        for (int i = 0; i < 17; i++) begin
            Write_Enable = 1'b1; Write_Byte = 8'(i + 1);
            exp_q.push_back(8'(i + 1));
            tick;
            exp_cnt = (i < 2) ? 1 : i;
            checks++; if (Count !== 5'(exp_cnt) || FIFO_Full !== (exp_cnt == 16)) begin failures++; $display("FAIL burst_count[%0d]: count=%0d full=%b want %0d", i, Count, FIFO_Full, exp_cnt); end
            if (i == 1) begin
                checks++; if (TX_Send !== 1'b1 || Input_Byte !== exp_q[0]) begin failures++; $display("FAIL burst_first: send=%b byte=%h want 1/%h", TX_Send, Input_Byte, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (i == 2) TX_Active = 1'b1;
        end
        Write_Byte = 8'hEE;
        tick;
        Write_Enable = 1'b0;
        checks++; if (Overflow !== 1'b1 || Count !== 5'd16) begin failures++; $display("FAIL overflow_pulse: ovf=%b count=%0d want 1/16", Overflow, Count); end
        tick;
        checks++; if (Overflow !== 1'b0 || Count !== 5'd16) begin failures++; $display("FAIL overflow_clear: ovf=%b count=%0d want 0/16", Overflow, Count); end
        TX_Active = 1'b0;
        for (int i = 0; i < 16; i++) run_frame(4);
        tick;
        tick;
        checks++; if (FIFO_Empty !== 1'b1 || Count !== 5'd0 || Busy !== 1'b0) begin failures++; $display("FAIL drain_end: empty=%b count=%0d busy=%b want 1/0/0", FIFO_Empty, Count, Busy); end
        checks++; if (exp_q.size() != 0 || TX_Send !== 1'b0) begin failures++; $display("FAIL drain_leftover: left=%0d send=%b want 0/0", exp_q.size(), TX_Send); end
    endtask

    task automatic test_timeout;
        int lat;
        Write_Enable = 1'b1; Write_Byte = 8'h3C;
        tick;
        Write_Enable = 1'b0;
        tick;
        checks++; if (TX_Send !== 1'b1 || Input_Byte !== 8'h3C) begin failures++; $display("FAIL timeout_launch: send=%b byte=%h want 1/3c", TX_Send, Input_Byte); end
        lat = 0;
        while (Send_Error !== 1'b1 && lat < 30) begin
            tick;
            lat++;
        end
        checks++; if (lat != 9) begin failures++; $display("FAIL timeout_delay: got %0d cycles want 9", lat); end
        checks++; if (Busy !== 1'b0 || Count !== 5'd0 || FIFO_Empty !== 1'b1) begin failures++; $display("FAIL timeout_idle: busy=%b count=%0d empty=%b want 0/0/1", Busy, Count, FIFO_Empty); end
        tick;
        checks++; if (Send_Error !== 1'b0 || TX_Send !== 1'b0) begin failures++; $display("FAIL timeout_pulse: err=%b send=%b want 0/0", Send_Error, TX_Send); end
    endtask

    task automatic test_back_to_back;
        Write_Enable = 1'b1; Write_Byte = 8'h55;
        tick;
        Write_Byte = 8'h66;
        tick;
        Write_Enable = 1'b0;
        checks++; if (TX_Send !== 1'b1 || Input_Byte !== 8'h55) begin failures++; $display("FAIL b2b_first: send=%b byte=%h want 1/55", TX_Send, Input_Byte); end
        tick;
        TX_Active = 1'b1;
        repeat (4) tick;
        TX_Active = 1'b0; Write_Enable = 1'b1; Write_Byte = 8'h77;
        tick;
        Write_Enable = 1'b0;
        checks++; if (TX_Send !== 1'b0 || Count !== 5'd2) begin failures++; $display("FAIL b2b_sample: send=%b count=%0d want 0/2", TX_Send, Count); end
        tick;
        checks++; if (TX_Send !== 1'b1 || Input_Byte !== 8'h66 || Count !== 5'd1) begin failures++; $display("FAIL b2b_next: send=%b byte=%h count=%0d want 1/66/1", TX_Send, Input_Byte, Count); end
        tick;
        TX_Active = 1'b1;
        repeat (3) tick;
        TX_Active = 1'b0;
        exp_q.push_back(8'h77);
        run_frame(3);
        tick;
        tick;
        checks++; if (Busy !== 1'b0 || FIFO_Empty !== 1'b1) begin failures++; $display("FAIL b2b_end: busy=%b empty=%b want 0/1", Busy, FIFO_Empty); end
    endtask

    task automatic test_spurious;
        TX_Active = 1'b1;
        tick;
        tick;
        checks++; if (TX_Send !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL spurious_idle: send=%b busy=%b want 0/0", TX_Send, Busy); end
        Write_Enable = 1'b1; Write_Byte = 8'h42;
        tick;
        Write_Enable = 1'b0;
        tick;
        checks++; if (TX_Send !== 1'b1 || Input_Byte !== 8'h42) begin failures++; $display("FAIL spurious_launch: send=%b byte=%h want 1/42", TX_Send, Input_Byte); end
        tick;
        tick;
        TX_Active = 1'b0;
        tick;
        tick;
        checks++; if (Busy !== 1'b0 || Send_Error !== 1'b0) begin failures++; $display("FAIL spurious_end: busy=%b err=%b want 0/0", Busy, Send_Error); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        Write_Enable = 1'b1; Write_Byte = 8'hFF;
        tick;
        Write_Enable = 1'b0;
        tick;
        tick;
        TX_Active = 1'b1;
        tick;
        Write_Enable = 1'b1;
        Write_Byte = 8'h11; tick;
        Write_Byte = 8'h22; tick;
        Write_Byte = 8'h33; tick;
        Write_Enable = 1'b0;
        checks++; if (Count !== 5'd3 || Busy !== 1'b1 || Input_Byte !== 8'hFF) begin failures++; $display("FAIL midreset_setup: count=%0d busy=%b byte=%h want 3/1/ff", Count, Busy, Input_Byte); end
        #2 Reset_N = 1'b0;
        #1;
        checks++; if (Count !== 5'd0 || FIFO_Empty !== 1'b1 || FIFO_Full !== 1'b0) begin failures++; $display("FAIL midreset_queue: count=%0d empty=%b full=%b want 0/1/0", Count, FIFO_Empty, FIFO_Full); end
        checks++; if (Busy !== 1'b0 || TX_Send !== 1'b0 || Input_Byte !== 8'h00) begin failures++; $display("FAIL midreset_fsm: busy=%b send=%b byte=%h want 0/0/00", Busy, TX_Send, Input_Byte); end
        TX_Active = 1'b0;
        tick;
        Reset_N = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick;
            if (TX_Send === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || FIFO_Empty !== 1'b1 || Count !== 5'd0) begin failures++; $display("FAIL midreset_after: resend=%b empty=%b count=%0d want 0/1/0", seen, FIFO_Empty, Count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst_full;
        test_timeout;
        test_back_to_back;
        test_spurious;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
